// File: rtl/opennic_axil_pkg.sv
// Shared register map, response codes and FSM state types for the OpenNIC
// AXI4-Lite control register block.
package opennic_axil_pkg;

  localparam logic [15:0] REG_ID       = 16'h0000;
  localparam logic [15:0] REG_CTRL     = 16'h1000;
  localparam logic [15:0] REG_SCRATCH  = 16'h1004;
  localparam logic [15:0] REG_PKT_CNT  = 16'h1008;
  localparam logic [15:0] REG_DROP_CNT = 16'h100C;
  localparam logic [15:0] REG_CNT_CLR  = 16'h1010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Word-aligned register offset from the low address bits.
  function automatic logic [15:0] reg_off(input logic [15:0] addr);
    return {addr[15:2], 2'b00};
  endfunction

  function automatic logic reg_mapped(input logic [15:0] off);
    case (off)
      REG_ID, REG_CTRL, REG_SCRATCH,
      REG_PKT_CNT, REG_DROP_CNT, REG_CNT_CLR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axil_ctrl_regs_if.sv
// AXI4-Lite bus bundle between the shell master and the control register block.
interface axil_ctrl_regs_if #(
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [31:0]       wdata;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module axil_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt_q <= '0;
    else if (clr)                   cnt_q <= '0;
    else if (inc && (cnt_q != '1))  cnt_q <= cnt_q + W'(1);
  end

  assign value = cnt_q;
endmodule

// File: rtl/axil_ctrl_regs.sv
// AXI4-Lite register block: ID, CTRL, SCRATCH and (with AXIL_CTRL_REGS_COUNTERS_EN
// defined) saturating packet/drop counters with a write-one clear.
module axil_ctrl_regs #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] BLOCK_ID = 32'h4F4E_0001
) (
  input  logic             axil_aclk,
  input  logic             axil_arst,
  axil_ctrl_regs_if.slave  s_axil,
  output logic             ctrl_enable,
  output logic             ctrl_drop_all,
  input  logic             pkt_inc,
  input  logic             drop_inc
);
  import opennic_axil_pkg::*;

  wr_state_e   wr_state;
  rd_state_e   rd_state;
  logic [15:0] aw_off_q;
  logic [31:0] wdata_q;
  logic [1:0]  ctrl_q;
  logic [31:0] scratch_q;
  logic [31:0] pkt_cnt, drop_cnt;

  logic        aw_hs, w_hs, ar_hs, b_hs;
  logic        wr_go, cnt_clr;
  logic [15:0] wr_off, rd_off;
  logic [31:0] wr_data, rd_data;
  logic [1:0]  rd_resp;

  assign aw_hs = s_axil.awvalid & s_axil.awready;
  assign w_hs  = s_axil.wvalid  & s_axil.wready;
  assign ar_hs = s_axil.arvalid & s_axil.arready;
  assign b_hs  = s_axil.bvalid  & s_axil.bready;

  // Commit uses whichever half arrives this cycle, else the half latched earlier.
  always_comb begin
    wr_go   = 1'b0;
    wr_off  = aw_hs ? reg_off(s_axil.awaddr[15:0]) : aw_off_q;
    wr_data = w_hs ? s_axil.wdata : wdata_q;
    case (wr_state)
      WR_IDLE:   wr_go = aw_hs & w_hs;
      WR_GOT_AW: wr_go = w_hs;
      WR_GOT_W:  wr_go = aw_hs;
      WR_RESP:   wr_go = 1'b0;
    endcase
  end

  assign cnt_clr = wr_go && (wr_off == REG_CNT_CLR) && wr_data[0];

  always_ff @(posedge axil_aclk or posedge axil_arst) begin
    if (axil_arst) begin
      wr_state       <= WR_IDLE;
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
      aw_off_q       <= '0;
      wdata_q        <= '0;
      ctrl_q         <= '0;
      scratch_q      <= '0;
    end else begin
      if (aw_hs) aw_off_q <= reg_off(s_axil.awaddr[15:0]);
      if (w_hs)  wdata_q  <= s_axil.wdata;
      if (wr_go) begin
        wr_state       <= WR_RESP;
        s_axil.awready <= 1'b0;
        s_axil.wready  <= 1'b0;
        s_axil.bvalid  <= 1'b1;
        s_axil.bresp   <= reg_mapped(wr_off) ? RESP_OKAY : RESP_SLVERR;
        case (wr_off)
          REG_CTRL:    ctrl_q    <= wr_data[1:0];
          REG_SCRATCH: scratch_q <= wr_data;
          default:     ;
        endcase
      end else begin
        case (wr_state)
          WR_IDLE: begin
            if (aw_hs) begin
              wr_state       <= WR_GOT_AW;
              s_axil.awready <= 1'b0;
              s_axil.wready  <= 1'b1;
            end else if (w_hs) begin
              wr_state       <= WR_GOT_W;
              s_axil.awready <= 1'b1;
              s_axil.wready  <= 1'b0;
            end else begin
              s_axil.awready <= 1'b1;
              s_axil.wready  <= 1'b1;
            end
          end
          WR_GOT_AW, WR_GOT_W: ;
          WR_RESP: begin
            if (b_hs) begin
              wr_state       <= WR_IDLE;
              s_axil.awready <= 1'b1;
              s_axil.wready  <= 1'b1;
              s_axil.bvalid  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign ctrl_enable   = ctrl_q[0];
  assign ctrl_drop_all = ctrl_q[1];

  // Read mux sees pre-commit register values, so a same-edge write is not visible.
  always_comb begin
    rd_off  = reg_off(s_axil.araddr[15:0]);
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_off)
      REG_ID:       rd_data = BLOCK_ID;
      REG_CTRL:     rd_data = {30'd0, ctrl_q};
      REG_SCRATCH:  rd_data = scratch_q;
      REG_PKT_CNT:  rd_data = pkt_cnt;
      REG_DROP_CNT: rd_data = drop_cnt;
      REG_CNT_CLR:  rd_data = '0;
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge axil_aclk or posedge axil_arst) begin
    if (axil_arst) begin
      rd_state       <= RD_IDLE;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rdata   <= '0;
      s_axil.rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state       <= RD_DATA;
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b1;
            s_axil.rdata   <= rd_data;
            s_axil.rresp   <= rd_resp;
          end else begin
            s_axil.arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s_axil.rready) begin
            rd_state       <= RD_IDLE;
            s_axil.arready <= 1'b1;
            s_axil.rvalid  <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef AXIL_CTRL_REGS_COUNTERS_EN
  axil_sat_counter #(.W(32)) u_pkt_cnt (
    .clk   (axil_aclk),
    .rst   (axil_arst),
    .inc   (pkt_inc),
    .clr   (cnt_clr),
    .value (pkt_cnt)
  );

  axil_sat_counter #(.W(32)) u_drop_cnt (
    .clk   (axil_aclk),
    .rst   (axil_arst),
    .inc   (drop_inc),
    .clr   (cnt_clr),
    .value (drop_cnt)
  );

  logic unused_bits;
  assign unused_bits = ^{s_axil.awaddr[ADDR_W-1:16], s_axil.araddr[ADDR_W-1:16]};
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;

  logic unused_bits;
  assign unused_bits = ^{s_axil.awaddr[ADDR_W-1:16], s_axil.araddr[ADDR_W-1:16],
                         pkt_inc, drop_inc, cnt_clr};
`endif

endmodule
